row_scan_sequencer: RTL and testbench



---
 rtl/scan_pkg.sv | 14 +
 rtl/row_scan_sequencer_if.sv | 24 ++
 rtl/scan_timer.sv | 31 +++
 rtl/row_scan_sequencer.sv | 110 +++++++++++
 tb/tb_row_scan_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// Shared scan-matrix definitions: FSM state encoding and row geometry,
// reused by the row sequencer and the matching column sampler.
package scan_pkg;

   localparam int ROWS  = 4;
   localparam int SEL_W = $clog2(ROWS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

endpackage

// File: rtl/row_scan_sequencer_if.sv
// Control/status bundle between a scan controller (master) and the row sequencer (slave).
interface row_scan_sequencer_if #(
   parameter int DWELL_W = 8
);
   import scan_pkg::*;

   logic               run;
   logic [DWELL_W-1:0] dwell;
   logic [SEL_W-1:0]   sel;
   logic               en_n;
   logic               row_strobe;
   logic               frame_done;

   modport master (
      output run, dwell,
      input  sel, en_n, row_strobe, frame_done
   );

   modport slave (
      input  run, dwell,
      output sel, en_n, row_strobe, frame_done
   );

endinterface

// File: rtl/scan_timer.sv
// Loadable down-counter shared by the blanking gap and the row dwell.
// o_tc marks the final cycle of an interval, o_last the cycle before it.
module scan_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_tc,
   output logic         o_last
);

   logic [W-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_tc   = (r_count == '0);
   assign o_last = (r_count == W'(1));

endmodule

// File: rtl/row_scan_sequencer.sv
// Row scan sequencer for a 2-to-4 decoder: cycles rows 0..3 with a forced
// blanking gap so the select only moves while the decoder is disabled.
module row_scan_sequencer
   import scan_pkg::*;
#(
   parameter int DWELL_W      = 8,
   parameter int BLANK_CYCLES = 2
) (
   input logic                 clk,
   input logic                 rst,
   row_scan_sequencer_if.slave scan_if
);

   localparam logic [DWELL_W-1:0] BLANK_LOAD = DWELL_W'(BLANK_CYCLES - 1);
   localparam logic [SEL_W-1:0]   LAST_ROW   = SEL_W'(ROWS - 1);

   scan_state_t        r_state;
   logic [SEL_W-1:0]   r_sel;
   logic               r_en_n;
   logic               r_row_strobe;
   logic               r_frame_done;

   logic               w_tc;
   logic               w_last;
   logic               w_load;
   logic [DWELL_W-1:0] w_load_val;
   logic [DWELL_W-1:0] w_dwell_eff;
   logic               w_dwell_one;

   assign w_dwell_eff = (scan_if.dwell == '0) ? DWELL_W'(1) : scan_if.dwell;
   assign w_dwell_one = (w_dwell_eff == DWELL_W'(1));

   // Timer is reloaded on every entry into BLANK or DRIVE; it holds the latched dwell.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
      w_load     = 1'b0;
      w_load_val = BLANK_LOAD;
      case (r_state)
         IDLE:  w_load = scan_if.run;
         BLANK: begin
            w_load     = w_tc;
            w_load_val = w_dwell_eff - DWELL_W'(1);
         end
         DRIVE: w_load = w_tc && scan_if.run;
         default: ;
      endcase
   end

   scan_timer #(.W(DWELL_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_tc       (w_tc),
      .o_last     (w_last)
   );

   // Strobes are registered one cycle early so they coincide with the final drive cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_sel        <= '0;
         r_en_n       <= 1'b1;
         r_row_strobe <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_en_n       <= 1'b1;
               r_row_strobe <= 1'b0;
               r_frame_done <= 1'b0;
               if (scan_if.run) begin
                  r_state <= BLANK;
                  r_sel   <= '0;
               end
            end
            BLANK: begin
               if (w_tc) begin
                  r_state      <= DRIVE;
                  r_en_n       <= 1'b0;
                  r_row_strobe <= w_dwell_one;
                  r_frame_done <= w_dwell_one && (r_sel == LAST_ROW);
               end
            end
            DRIVE: begin
               if (w_tc) begin
                  r_sel        <= r_sel + SEL_W'(1);
                  r_en_n       <= 1'b1;
                  r_row_strobe <= 1'b0;
                  r_frame_done <= 1'b0;
                  r_state      <= scan_if.run ? BLANK : IDLE;
               end else begin
                  r_row_strobe <= w_last;
                  r_frame_done <= w_last && (r_sel == LAST_ROW);
               end
            end
            default: begin
               r_state <= IDLE;
               r_en_n  <= 1'b1;
            end
         endcase
      end
   end

   assign scan_if.sel        = r_sel;
   assign scan_if.en_n       = r_en_n;
   assign scan_if.row_strobe = r_row_strobe;
   assign scan_if.frame_done = r_frame_done;

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Scoreboard bench for row_scan_sequencer: stimulus queues expected rows,
// a negedge monitor checks each strobe, drive-window length and select stability.
module tb_row_scan_sequencer;

   localparam int DWELL_W = 8;
   localparam int BLANK_C = 2;
   localparam int BOUND   = 2000;

   typedef struct {
      int sel;
      int frame;
      int len;
      int cyc;   // expected cycle index of the strobe, 0 = not checked
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   row_scan_sequencer_if #(.DWELL_W(DWELL_W)) bus_if ();

   row_scan_sequencer #(
      .DWELL_W      (DWELL_W),
      .BLANK_CYCLES (BLANK_C)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .scan_if (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic push(input int sel, input int len, input int cyc_exp);
      exp_t e;
      e.sel   = sel;
      e.frame = (sel == 3) ? 1 : 0;
      e.len   = len;
      e.cyc   = cyc_exp;
      sb_q.push_back(e);
   endtask

   task automatic wait_strobe(input string tag);
      bit found = 0;
      for (int k = 0; k < BOUND && !found; k++) begin
         @(negedge clk);
         if (bus_if.row_strobe) found = 1;
      end
      if (!found) check({tag, "_strobe_timeout"}, 0, 1);
   endtask

   task automatic wait_drive(input int sel, input string tag);
      bit found = 0;
      for (int k = 0; k < BOUND && !found; k++) begin
         @(negedge clk);
         if (!bus_if.en_n && bus_if.sel == 2'(sel)) found = 1;
      end
      if (!found) check({tag, "_drive_timeout"}, 0, 1);
   endtask

   // Monitor: runs independently of stimulus and consumes the scoreboard
   int   drive_len = 0;
   logic prev_en_n = 1'b1;
   logic [1:0] prev_sel = '0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         drive_len = 0;
      end else begin
         drive_len = bus_if.en_n ? 0 : drive_len + 1;
         if (!bus_if.en_n && !prev_en_n) check("sel_stable_in_drive", int'(bus_if.sel), int'(prev_sel));
         if (bus_if.frame_done) check("frame_done_with_strobe", int'(bus_if.row_strobe), 1);
         if (bus_if.row_strobe) begin
            if (sb_q.size() == 0) begin
               check("unexpected_strobe_sel", int'(bus_if.sel), -1);
            end else begin
               e = sb_q.pop_front();
               check("strobe_sel", int'(bus_if.sel), e.sel);
               check("strobe_en_n", int'(bus_if.en_n), 0);
               check("frame_done", int'(bus_if.frame_done), e.frame);
               check("drive_len", drive_len, e.len);
               if (e.cyc != 0) check("strobe_cycle", cyc + 1, e.cyc);
            end
         end
      end
      prev_en_n = bus_if.en_n;
      prev_sel  = bus_if.sel;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int dtab[40];

      bus_if.run   = 1'b0;
      bus_if.dwell = '0;

      // Reset and idle: outputs quiet, no strobes for 50 cycles
      repeat (3) @(negedge clk);
      check("reset_sel", int'(bus_if.sel), 0);
      check("reset_en_n", int'(bus_if.en_n), 1);
      check("reset_strobe", int'(bus_if.row_strobe), 0);
      check("reset_frame", int'(bus_if.frame_done), 0);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      check("idle_en_n", int'(bus_if.en_n), 1);
      check("idle_sel", int'(bus_if.sel), 0);

      // Basic scan, dwell 3: strobes at t+5, t+10, t+15, t+20
      bus_if.dwell = 8'd3;
      bus_if.run   = 1'b1;
      t = cyc + 1;
      for (int r = 0; r < 4; r++) push(r, 3, t + 5 * (r + 1));
      for (int r = 0; r < 4; r++) wait_strobe("basic");
      bus_if.run = 1'b0;
      repeat (3) @(negedge clk);
      check("basic_stop_en_n", int'(bus_if.en_n), 1);
      check("basic_wrap_sel", int'(bus_if.sel), 0);

      // Dwell 0 behaves as a single-cycle drive window
      bus_if.dwell = 8'd0;
      bus_if.run   = 1'b1;
      for (int r = 0; r < 4; r++) push(r, 1, 0);
      for (int r = 0; r < 4; r++) wait_strobe("dwell0");
      bus_if.run = 1'b0;
      repeat (3) @(negedge clk);
      check("dwell0_stop_sel", int'(bus_if.sel), 0);

      // Stop during the second drive cycle of row 1: row still completes
      bus_if.dwell = 8'd3;
      push(0, 3, 0);
      push(1, 3, 0);
      bus_if.run = 1'b1;
      wait_strobe("stop_r0");
      wait_drive(1, "stop_r1");
      @(negedge clk);
      bus_if.run = 1'b0;
      wait_strobe("stop_r1");
      repeat (4) @(negedge clk);
      check("stop_idle_en_n", int'(bus_if.en_n), 1);
      check("stop_idle_sel", int'(bus_if.sel), 2);
      push(0, 3, 0);
      bus_if.run = 1'b1;
      wait_strobe("restart");
      bus_if.run = 1'b0;
      repeat (3) @(negedge clk);
      check("restart_sel", int'(bus_if.sel), 1);

      // Asynchronous reset during row 2 drive
      bus_if.dwell = 8'd5;
      push(0, 5, 0);
      push(1, 5, 0);
      bus_if.run = 1'b1;
      wait_drive(2, "areset");
      #2 rst = 1'b1;
      #1;
      check("areset_en_n", int'(bus_if.en_n), 1);
      check("areset_sel", int'(bus_if.sel), 0);
      check("areset_strobe", int'(bus_if.row_strobe), 0);
      @(negedge clk);
      push(0, 5, 0);
      rst = 1'b0;
      wait_strobe("areset_restart");
      bus_if.run = 1'b0;
      repeat (3) @(negedge clk);
      check("areset_restart_sel", int'(bus_if.sel), 1);

      // Maximum dwell: counter must not overflow
      bus_if.dwell = 8'd255;
      push(0, 255, 0);
      bus_if.run = 1'b1;
      wait_strobe("max_dwell");
      bus_if.run = 1'b0;
      repeat (3) @(negedge clk);

      // Ten frames with the dwell changed every row
      for (int i = 0; i < 40; i++) dtab[i] = (i * 7 + 3) % 9;
      for (int i = 0; i < 40; i++) push(i % 4, (dtab[i] == 0) ? 1 : dtab[i], 0);
      bus_if.dwell = 8'(dtab[0]);
      bus_if.run   = 1'b1;
      for (int i = 0; i < 40; i++) begin
         wait_strobe("frames");
         if (i < 39) bus_if.dwell = 8'(dtab[i + 1]);
         else        bus_if.run = 1'b0;
      end
      repeat (6) @(negedge clk);
      check("frames_end_en_n", int'(bus_if.en_n), 1);
      check("scoreboard_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
